// File: rtl/intr_exce_ctrl.sv
// rtl/intr_exce_ctrl.sv - interrupt/exception controller: pending, priority, take/flush and kernel sequencing
// Optional INTR_STATS_EN adds the max_latency port and its latency counter.
module intr_exce_ctrl #(
    parameter int          NUM_IRQ = 4,
    parameter logic [31:0] VEC_INT = 32'h80000004,
    parameter logic [31:0] VEC_EXC = 32'h80000008
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [2:0]         exc_in,
    input  logic               kernel_mode,
    input  logic               eret,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic               take,
    output logic [31:0]        take_vec,
    output logic               flush,
    output logic [7:0]         cause,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic [2:0]         exc_sticky
`ifdef INTR_STATS_EN
    ,
    output logic [15:0]        max_latency
`endif
);

    typedef enum logic [1:0] {IDLE, ENTER, KERNEL} state_t;

    state_t             state_q, state_d;
    logic               take_q, take_d;
    logic [31:0]        vec_q, vec_d;
    logic [7:0]         cause_q, cause_d;
    logic [NUM_IRQ-1:0] ack_q, ack_d;
    logic [NUM_IRQ-1:0] irq_pend_q, irq_pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] prev_q, prev_d;
    logic [2:0]         exc_pend_q, exc_pend_d;
    logic [2:0]         sticky_q, sticky_d;

    logic [NUM_IRQ-1:0] irq_eff, irq_en;
    logic [2:0]         exc_eff, exc_clr;
    logic               eligible;
    logic [3:0]         irq_win;

    always_comb begin
        // A request edge seen this cycle counts immediately, giving one-cycle take latency.
        irq_eff  = irq_pend_q | (irq_in & ~prev_q);
        exc_eff  = exc_pend_q | exc_in;
        irq_en   = irq_eff & mask_q;
        eligible = (state_q == IDLE) && !kernel_mode && ((|exc_eff) || (|irq_en));

        irq_win = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_en[i]) irq_win = 4'(i);
        end

        state_d = state_q;
        take_d  = 1'b0;
        ack_d   = '0;
        exc_clr = '0;
        vec_d   = vec_q;
        cause_d = cause_q;

        case (state_q)
            IDLE: begin
                if (eligible) begin
                    state_d = ENTER;
                    take_d  = 1'b1;
                    if (|exc_eff) begin
                        vec_d = VEC_EXC;
                        if (exc_eff[2]) begin
                            exc_clr = 3'b100;
                            cause_d = 8'h82;
                        end else if (exc_eff[1]) begin
                            exc_clr = 3'b010;
                            cause_d = 8'h81;
                        end else begin
                            exc_clr = 3'b001;
                            cause_d = 8'h80;
                        end
                    end else begin
                        vec_d          = VEC_INT;
                        cause_d        = {4'h0, irq_win};
                        ack_d[irq_win] = 1'b1;
                    end
                end
            end
            ENTER:   state_d = KERNEL;
            KERNEL:  if (eret) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        irq_pend_d = irq_eff & ~ack_d;
        exc_pend_d = exc_eff & ~exc_clr;
        prev_d     = irq_in;
        mask_d     = mask_wr ? mask_wdata : mask_q;
        sticky_d   = sticky_q | exc_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            take_q     <= 1'b0;
            vec_q      <= '0;
            cause_q    <= '0;
            ack_q      <= '0;
            irq_pend_q <= '0;
            mask_q     <= '1;
            prev_q     <= '0;
            exc_pend_q <= '0;
            sticky_q   <= '0;
        end else begin
            state_q    <= state_d;
            take_q     <= take_d;
            vec_q      <= vec_d;
            cause_q    <= cause_d;
            ack_q      <= ack_d;
            irq_pend_q <= irq_pend_d;
            mask_q     <= mask_d;
            prev_q     <= prev_d;
            exc_pend_q <= exc_pend_d;
            sticky_q   <= sticky_d;
        end
    end

    assign take        = take_q;
    assign flush       = take_q;
    assign take_vec    = vec_q;
    assign cause       = cause_q;
    assign irq_ack     = ack_q;
    assign irq_pending = irq_pend_q;
    assign exc_sticky  = sticky_q;

`ifdef INTR_STATS_EN
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] max_q, max_d;
    logic        waiting;

    always_comb begin
        // Counts every cycle a serviceable request waits, kernel time included.
        waiting = (|exc_pend_q) || (|(irq_pend_q & mask_q));
        cnt_d   = cnt_q;
        max_d   = max_q;
        if (take_d) begin
            if (cnt_q > max_q) max_d = cnt_q;
            cnt_d = '0;
        end else if (waiting && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            max_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            max_q <= max_d;
        end
    end

    assign max_latency = max_q;
`endif

endmodule

// File: doc/intr_exce_ctrl.md
Name: intr_exce_ctrl

Overview:
Interrupt/exception controller for the 5-stage pipelined processor.
- Latches timer, UART and other peripheral requests plus core exceptions.
- Prioritises them and issues a single registered "take" with a vector PC, pipeline flush and cause code to the IF stage.
- Sequences entry to and return from kernel mode (PC[31]), so requests are never taken while the kernel handler runs.

Parameters:
NUM_IRQ, 4, number of peripheral request lines (bit 0 = timer, bit 1 = UART send); range 1..8
VEC_INT, 32'h80000004, vector PC for interrupts
VEC_EXC, 32'h80000008, vector PC for exceptions

Ports:
clk  in  1  processor clock
reset  in  1  asynchronous, active-low reset
irq_in  in  NUM_IRQ  level peripheral requests; a rising edge makes the request pending
exc_in  in  3  {core_hazard, pc_overflow, alu_overflow}; a high level in any cycle makes it pending
kernel_mode  in  1  PC_IF[31]
eret  in  1  one-cycle pulse: handler return (jr $26 back to user space)
mask_wr  in  1  write strobe for the irq mask
mask_wdata  in  NUM_IRQ  new mask; 1 = enabled
take  out  1  one-cycle pulse: redirect IF to take_vec
take_vec  out  32  VEC_EXC or VEC_INT, valid while take=1
flush  out  1  one-cycle pulse, concurrent with take; zeroes the IF instruction
cause  out  8  bit7 = exception, [3:0] = source index; held until next take
irq_ack  out  NUM_IRQ  one-hot pulse concurrent with take (interrupts only)
irq_pending  out  NUM_IRQ  current pending bits
exc_sticky  out  3  sticky log of every exception seen since reset (drives the LED)

Behaviour:
Reset values:
- take, flush, irq_ack, irq_pending, cause = 0; exc_sticky = 0.
- take_vec = 0; mask = all ones; prev irq_in = 0; state = IDLE.

Pending logic:
- irq_pending[i] sets on (irq_in[i] & ~prev[i]) and clears on irq_ack[i].
- If set and clear fall on the same cycle, set wins.
- exc_pend[j] sets when exc_in[j]=1 and clears when that exception is taken.
- exc_sticky[j] |= exc_in[j], in every state.

Eligibility (IDLE only):
- Eligible when kernel_mode=0 and (|exc_pend or |(irq_pending & mask)).

Priority: exceptions (core_hazard > pc_overflow > alu_overflow) > enabled irq, lowest index first.

FSM:
- IDLE: if eligible at edge N, move to ENTER. During cycle N+1: take=1, flush=1, take_vec and cause per the winning source, irq_ack one-hot (interrupt only), winning pending bit cleared.
- ENTER: lasts exactly one cycle, then moves to KERNEL. eret is ignored here.
- KERNEL: waits for eret, then returns to IDLE. New requests stay pending; exceptions are only logged and stay pending; no take is issued.
- eret in IDLE: ignored.

Other rules:
- mask_wr updates the mask at the next edge in any state; masked requests stay pending and become eligible once unmasked.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); pending requests are lost.
- Worst-case take latency from a request edge in IDLE: 1 cycle.

Optional Feature:
INTR_STATS_EN:
- Defined: adds output max_latency[15:0], reset 0.
- A 16-bit counter runs while any eligible-but-untaken pending exists, including cycles spent in KERNEL.
- At each take, max_latency = max(max_latency, counter), then the counter clears.
- Both counter and max_latency saturate at 16'hFFFF.
- Undefined: no port and no logic.

Test Plan:
- Reset release, irq_in[0] rises at cycle 5 -> take=1, take_vec=32'h80000004, cause=8'h00, irq_ack=4'b0001 in cycle 6 only; then KERNEL.
- Same cycle: exc_in=3'b010 and irq_in[1] rising -> take_vec=32'h80000008, cause=8'h81; irq_pending[1] stays 1; after eret (kernel_mode=0), second take with cause=8'h01.
- kernel_mode=1 in IDLE with irq_in[0] rising -> no take; kernel_mode drops to 0 -> take next cycle.
- mask_wdata=4'b1101 written, irq_in[1] rises -> irq_pending=4'b0010, no take; remask 4'b1111 -> take with cause=8'h01.
- irq_in[2] rises in the cycle irq_ack[2] pulses -> irq_pending[2] remains 1.
- reset asserted in KERNEL with pending bits set -> all outputs 0 asynchronously; exc_sticky=0; mask=all ones.
